// File: rtl/seg7_monitor.sv
// seg7_monitor: glitch-filtering decoder for an active-low HEX segment bus with digit history.
// Define SEG7_MON_MATCH_EN to build the history-vs-EXPECT_ID comparator driving match.
module seg7_monitor #(
    parameter int          STABLE_CYCLES = 4,
    parameter int          ID_LEN        = 8,
    parameter logic [31:0] EXPECT_ID     = 32'h0123_4567
) (
    input  logic        clk_50M,
    input  logic        reset,
    input  logic        clr,
    input  logic [6:0]  seg_in,
    output logic [3:0]  digit,
    output logic        digit_valid,
    output logic        bad_pat,
    output logic        err,
    output logic [31:0] history,
    output logic [3:0]  dig_cnt,
    output logic        match
);
    localparam logic [7:0]  SC   = 8'(STABLE_CYCLES);
    localparam logic [31:0] MASK = 32'hFFFF_FFFF >> (32 - 4 * ID_LEN);
    logic [6:0] seg_q, last_acc;
    logic [7:0] stab;
    logic [3:0] dec;
    logic       glyph, blank, accept;
    always_comb begin
        glyph = 1'b1;
        dec   = 4'h0;
        case (seg_q)
            7'h40: dec = 4'h0;
            7'h79: dec = 4'h1;
            7'h24: dec = 4'h2;
            7'h30: dec = 4'h3;
            7'h19: dec = 4'h4;
            7'h12: dec = 4'h5;
            7'h02: dec = 4'h6;
            7'h78: dec = 4'h7;
            7'h00: dec = 4'h8;
            7'h10: dec = 4'h9;
            7'h08: dec = 4'hA;
            7'h03: dec = 4'hB;
            7'h46: dec = 4'hC;
            7'h21: dec = 4'hD;
            7'h06: dec = 4'hE;
            7'h0E: dec = 4'hF;
            default: glyph = 1'b0;
        endcase
    end
    assign blank  = seg_q == 7'h7F;
    // Fires once per qualified run; last_acc blocks re-acceptance of a held pattern
    assign accept = seg_in == seg_q && stab == SC - 8'd1 && seg_q != last_acc;
    always_ff @(posedge clk_50M) begin
        if (!reset) begin
            seg_q       <= 7'h7F;
            stab        <= 8'd0;
            last_acc    <= 7'h7F;
            digit       <= 4'h0;
            digit_valid <= 1'b0;
            bad_pat     <= 1'b0;
            err         <= 1'b0;
            history     <= 32'h0;
            dig_cnt     <= 4'h0;
        end else begin
            seg_q       <= seg_in;
            stab        <= seg_in != seg_q ? 8'd0 : stab == SC ? stab : stab + 8'd1;
            digit_valid <= accept && glyph;
            bad_pat     <= accept && !glyph && !blank;
            if (accept) last_acc <= seg_q;
            if (accept && glyph) digit <= dec;
            if (clr) begin
                history <= 32'h0;
                dig_cnt <= 4'h0;
                err     <= 1'b0;
            end else begin
                if (accept && glyph) begin
                    history <= {history[27:0], dec} & MASK;
                    dig_cnt <= dig_cnt + {3'd0, dig_cnt != 4'hF};
                end
                if (accept && !glyph && !blank) err <= 1'b1;
            end
        end
    end
`ifdef SEG7_MON_MATCH_EN
    localparam logic [3:0] ID4 = 4'(ID_LEN);
    always_ff @(posedge clk_50M) begin
        if (!reset || clr) match <= 1'b0;
        else match <= dig_cnt >= ID4 && (history & MASK) == (EXPECT_ID & MASK);
    end
`else
    assign match = 1'b0;
`endif
endmodule

// File: tb/tb_seg7_monitor.sv
// tb_seg7_monitor: randomized scoreboard bench for seg7_monitor against a run-length reference model.
module tb_seg7_monitor;
    localparam int          SC     = 4;
    localparam int          ID_LEN = 8;
    localparam logic [31:0] EXP_ID = 32'h0123_4567;
    localparam logic [6:0]  GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk_50M = 1'b0, reset = 1'b0, clr = 1'b0;
    logic [6:0]  seg_in = 7'h7F;
    logic [3:0]  digit, dig_cnt;
    logic        digit_valid, bad_pat, err, match;
    logic [31:0] history;

    seg7_monitor #(.STABLE_CYCLES(SC), .ID_LEN(ID_LEN), .EXPECT_ID(EXP_ID)) dut (
        .clk_50M(clk_50M), .reset(reset), .clr(clr), .seg_in(seg_in),
        .digit(digit), .digit_valid(digit_valid), .bad_pat(bad_pat), .err(err),
        .history(history), .dig_cnt(dig_cnt), .match(match)
    );

    always #5 clk_50M = ~clk_50M;

    int cyc = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    int tests = 0, fails = 0;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %h expected %h (edge %0d)", n, a, x, cyc);
        end
    endtask

    typedef struct {
        int          e;
        bit          bad;
        logic [3:0]  d;
        logic [31:0] h;
        logic [3:0]  c;
    } ev_t;
    ev_t sb[$];

    // Reference model: a pattern is taken once it has been seen SC+1 samples in a row
    logic [6:0]  prev = 7'h7F, last = 7'h7F;
    int          run = 1;
    logic [3:0]  hq[$];
    logic [31:0] m_hist = 0;
    logic [3:0]  m_cnt = 0, m_digit = 0;
    logic        m_err = 0, m_match = 0;

    function automatic int gidx(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (GLY[i] == p) return i;
        return -1;
    endfunction

    task automatic step(input logic [6:0] p, input bit c = 0, input bit r = 1);
        bit   ev, bad, mm;
        int   g;
        ev_t  it;
        @(negedge clk_50M);
        chk("history", history, m_hist);
        chk("dig_cnt", {28'd0, dig_cnt}, {28'd0, m_cnt});
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("digit", {28'd0, digit}, {28'd0, m_digit});
        chk("match", {31'd0, match}, {31'd0, m_match});
        seg_in = p;
        clr    = c;
        reset  = r;
        if (!r) begin
            prev = 7'h7F; last = 7'h7F; run = 1;
            hq.delete(); m_cnt = 0; m_digit = 0; m_err = 0; m_match = 0; m_hist = 0;
        end else begin
            mm  = m_cnt >= ID_LEN && m_hist == (EXP_ID & (32'hFFFF_FFFF >> (32 - 4 * ID_LEN)));
            run = (p == prev) ? run + 1 : 1;
            prev = p;
            ev  = 0;
            bad = 0;
            g   = gidx(p);
            if (run == SC + 1 && p != last) begin
                last = p;
                if (g >= 0) begin
                    ev = 1;
                    m_digit = 4'(g);
                    hq.push_back(4'(g));
                    if (hq.size() > ID_LEN) void'(hq.pop_front());
                    if (m_cnt != 15) m_cnt++;
                end else if (p != 7'h7F) begin
                    ev = 1;
                    bad = 1;
                    m_err = 1;
                end
            end
`ifdef SEG7_MON_MATCH_EN
            m_match = mm;
`else
            m_match = 0 & mm;
`endif
            if (c) begin
                hq.delete(); m_cnt = 0; m_err = 0; m_match = 0;
            end
            m_hist = 0;
            foreach (hq[i]) m_hist = (m_hist << 4) | {28'd0, hq[i]};
            if (ev) begin
                it.e = cyc + 1; it.bad = bad; it.d = m_digit; it.h = m_hist; it.c = m_cnt;
                sb.push_back(it);
            end
        end
    endtask

    task automatic hold(input logic [6:0] p, input int n, input bit c = 0);
        for (int i = 0; i < n; i++) step(p, c);
    endtask

    // Monitor: every output pulse must match the oldest expected event, at its expected edge
    always @(negedge clk_50M) begin
        while (sb.size() > 0 && sb[0].e < cyc) begin
            chk("ev_missed", 32'(sb[0].e), 32'(cyc));
            void'(sb.pop_front());
        end
        if (digit_valid === 1'b1 || bad_pat === 1'b1) begin
            if (sb.size() == 0) chk("ev_unexpected", {30'd0, digit_valid, bad_pat}, 32'd0);
            else begin
                chk("ev_edge", 32'(cyc), 32'(sb[0].e));
                chk("ev_kind", {30'd0, digit_valid, bad_pat}, sb[0].bad ? 32'd1 : 32'd2);
                if (!sb[0].bad) chk("ev_digit", {28'd0, digit}, {28'd0, sb[0].d});
                chk("ev_hist", history, sb[0].h);
                chk("ev_cnt", {28'd0, dig_cnt}, {28'd0, sb[0].c});
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int k;
        hold(7'h7F, 3);
        step(7'h7F, 0, 0);
        step(7'h7F, 0, 0);
        hold(7'h7F, 3);
        hold(7'h40, 10); hold(7'h79, 10); hold(7'h24, 10);
        hold(7'h79, 10); hold(7'h00, 2); hold(7'h79, 10);
        hold(7'h7F, 10); hold(7'h79, 10); hold(7'h79, 100);
        hold(7'h55, 6);
        step(7'h55, 1);
        hold(7'h7F, 6);
        for (int i = 0; i < 8; i++) begin
            hold(GLY[i], 6);
            hold(7'h7F, 6);
        end
        hold(GLY[8], 6);
        hold(7'h7F, 6);
        step(7'h79); step(7'h79);
        step(7'h79, 0, 0);
        hold(7'h79, 10);
        hold(7'h7F, 3);
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            hold(k < 6 ? GLY[$urandom_range(0, 15)] : k < 8 ? 7'h7F : 7'($urandom),
                 $urandom_range(1, 8), $urandom_range(0, 39) == 0);
        end
        hold(7'h7F, 10);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seg7_monitor.md
# seg7_monitor

Sampling decoder for the active-low 7-segment bus that drives the DE-series HEX displays. It watches one HEX segment vector and filters out glitches and transitional patterns. It decodes each stable glyph back to a hex digit and keeps a shift history of accepted digits. In self-check builds it flags when the history equals an expected digit sequence, such as the ID string a display block cycles through.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples needed to accept a pattern. Legal range 1..255.
- `ID_LEN`, default 8: number of digits in the history, and in the match window. Legal range 1..8.
- `EXPECT_ID`, default 32'h0123_4567: expected sequence, 4 bits per digit. The newest digit is in `[3:0]`; only the low `ID_LEN*4` bits are used.

Ports (name, direction, width, meaning):
- `clk_50M` in 1: 50 MHz clock. Every flop is on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `clr` in 1: synchronous clear of `history`, `dig_cnt`, `err` and `match`.
- `seg_in` in 7: monitored segments, active-low. Bit0 = a … bit6 = g.
- `digit` out 4: last accepted digit.
- `digit_valid` out 1: one-cycle pulse when a digit is accepted.
- `bad_pat` out 1: one-cycle pulse when a non-glyph pattern is accepted.
- `err` out 1: sticky; set by `bad_pat`.
- `history` out 32: accepted digits, newest in `[3:0]`. Bits above `ID_LEN*4` read 0.
- `dig_cnt` out 4: accepted digits since reset or `clr`, saturating at 15.
- `match` out 1: history equals `EXPECT_ID` (needs the configuration macro).

## Operation
- Glyph table (`seg_in` value → digit):
  - 40 → 0, 79 → 1, 24 → 2, 30 → 3
  - 19 → 4, 12 → 5, 02 → 6, 78 → 7
  - 00 → 8, 10 → 9, 08 → A, 03 → b
  - 46 → C, 21 → d, 06 → E, 0E → F
  - 7F → blank. Any other value is invalid.
- Input register: `seg_q <= seg_in` on every cycle.
- Stability counter `stab`, 8 bits:
  - Cleared when `seg_in != seg_q`, otherwise incremented.
  - Saturates at `STABLE_CYCLES`.
- Accept event: `seg_in == seg_q`, and `stab == STABLE_CYCLES-1`, and `seg_q != last_acc`.
- On an accept event, `last_acc <= seg_q`, then by pattern type:
  - Glyph: `digit` is loaded, `digit_valid` pulses, `history <= {history[27:0], d}` masked to `ID_LEN` digits, and `dig_cnt` increments.
  - Blank: no pulse and no history change. A blank is the separator that lets a repeated digit (e.g. "11") be recognised twice.
  - Invalid: `bad_pat` pulses and `err` is set. `history` is unchanged.
- A pattern equal to `last_acc` is never re-accepted, however long it is held.
- `clr` together with an accept: `clr` wins for `history`, `dig_cnt`, `err` and `match`. `last_acc` and `digit` still update, and the pulses still fire.
- Reset values: `digit` = 0, `digit_valid` = 0, `bad_pat` = 0, `err` = 0, `history` = 0, `dig_cnt` = 0, `match` = 0, `last_acc` = 7'h7F, `seg_q` = 7'h7F, `stab` = 0.
- Reset mid-stream: any partially qualified pattern is discarded. A pattern held across the reset release must re-qualify from `stab` = 0.

## Timing
- Let the new pattern be P, first sampled at edge k (`seg_q` differs from `seg_in` at that edge).
  - `digit`, `digit_valid`, `bad_pat`, `history` and `dig_cnt` update at edge k+`STABLE_CYCLES`.
  - With `STABLE_CYCLES` = 4, `digit_valid` is high for exactly the cycle after edge k+4.
- A pattern held for fewer than `STABLE_CYCLES` edges after edge k produces no event.
- Minimum spacing between two accepts is `STABLE_CYCLES`+1 cycles.
- `match` is registered and updates one cycle after `history`.
- `seg_in` is assumed synchronous to `clk_50M`. The block has no synchroniser stage.

## Configuration
- Macro `SEG7_MON_MATCH_EN`.
- Defined:
  - `match` is 1 when `dig_cnt >= ID_LEN` and `history[ID_LEN*4-1:0] == EXPECT_ID[ID_LEN*4-1:0]`.
  - `match` is re-evaluated after every history change and drops on `clr`.
- Undefined: the comparator is not built and `match` is tied to 0.

## Test plan
- Reset, then hold 40, 79, 24 for 10 cycles each (`STABLE_CYCLES` = 4) → `digit_valid` pulses 3 times, each 4 edges after its change, with `digit` = 0, 1, 2; `history[11:0]` = 12'h012, `dig_cnt` = 3.
- Hold 79, glitch to 00 for 2 cycles, return to 79 → no second `digit_valid` and no 8 in `history`.
- Apply 79, 7F, 79 → two `digit_valid` pulses, `history[7:0]` = 8'h11. Apply 79, 79 held for 100 cycles → a single pulse.
- Apply 55 for 6 cycles → `bad_pat` pulses once, `err` stays 1, `history` is unchanged. Assert `clr` → `err` = 0, `history` = 0, `dig_cnt` = 0.
- With `SEG7_MON_MATCH_EN` defined and the default parameters, feed the glyphs for 0,1,2,3,4,5,6,7 separated by blanks → `match` = 1 one cycle after the 7 is accepted. Feeding an extra 8 → `match` = 0.
- Pull `reset` low for 1 cycle 2 edges into a qualifying 79 → all outputs return to reset values. The held 79 then accepts 4 edges after reset release.
